fir_channel_scheduler: RTL and testbench

FIR_CHANNEL_SCHEDULER -- requirements
Module: fir_channel_scheduler

---
 rtl/fir_sched_pkg.sv | 22 ++
 rtl/fir_rr_arbiter.sv | 32 +++
 rtl/fir_channel_scheduler.sv | 153 +++++++++++++++
 tb/tb_fir_channel_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sched_pkg.sv
// Shared types, default sizes and reset coefficients for the channel-multiplexed FIR.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_TAPS   = 4;
  localparam int DEF_DW     = 8;
  localparam int DEF_OW     = 16;

  // Reset coefficient for tap k: a simple ramp 1,2,3,... so an impulse reads the taps back.
  function automatic int default_coef(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fir_rr_arbiter.sv
// Round-robin arbiter: picks the first requester after ptr, wrapping modulo NUM_CH.
// Latency: purely combinational.
// Backpressure: none; grant is all-zero when no request is present.
module fir_rr_arbiter
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     idx
);

  logic found;

  // Scan ptr+1, ptr+2, ... ptr+NUM_CH (ptr itself last) and take the first requester.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_CH; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_CH]) begin
        found                             = 1'b1;
        grant[(int'(ptr) + i) % NUM_CH]   = 1'b1;
        idx                               = CW'((int'(ptr) + i) % NUM_CH);
      end
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-multiplexed FIR: NUM_CH channels share one MAC, serviced round-robin, one sample at a time.
// Latency: result valid TAPS+1 edges after the accepting edge (counting it); sample period >= TAPS+2 cycles.
// Backpressure: result held in OUT until out_ready; no new sample is accepted until it is taken.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int TAPS   = DEF_TAPS,
  parameter int DW     = DEF_DW,
  parameter int OW     = DEF_OW,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TW    = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CH-1:0]    in_valid,
  input  logic [NUM_CH*DW-1:0] in_data,
  output logic [NUM_CH-1:0]    in_ready,
  output logic                 out_valid,
  output logic [OW-1:0]        out_data,
  output logic [CW-1:0]        out_ch,
  input  logic                 out_ready,
  input  logic                 coef_we,
  input  logic [TW-1:0]        coef_addr,
  input  logic [DW-1:0]        coef_data,
  output logic                 coef_busy
);

  state_t state, state_nxt;

  logic [CW-1:0]        rr_ptr;
  logic [CW-1:0]        cur_ch;
  logic [TW-1:0]        tap;
  logic signed [OW-1:0] acc;

  logic signed [DW-1:0] coef [TAPS];
  logic signed [DW-1:0] line [NUM_CH][TAPS];

  logic [NUM_CH-1:0]      arb_grant;
  logic [CW-1:0]          arb_idx;
  logic                   grant_en;
  logic signed [DW-1:0]   new_smp;
  logic signed [DW-1:0]   mac_coef;
  logic signed [DW-1:0]   mac_smp;
  logic signed [2*DW-1:0] mac_prod;

  fir_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_arb (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // Sample of the granted channel, and the single shared multiplier for the current tap.
  always_comb begin
    new_smp  = in_data[arb_idx*DW +: DW];
    mac_coef = coef[tap];
    mac_smp  = line[cur_ch][tap];
    mac_prod = mac_coef * mac_smp;
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; in_ready is gated by rst_n so nothing is accepted in reset.
  always_comb begin
    state_nxt = state;
    in_ready  = '0;
    grant_en  = 1'b0;
    coef_busy = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        if ((|in_valid) && rst_n) begin
          grant_en  = 1'b1;
          in_ready  = arb_grant;
          state_nxt = MAC;
        end
      end
      MAC: begin
        coef_busy = 1'b1;
        if (tap == TW'(TAPS - 1)) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, tap counter, result channel and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      tap    <= '0;
      cur_ch <= '0;
      rr_ptr <= CW'(NUM_CH - 1);
    end else if (grant_en) begin
      acc    <= '0;
      tap    <= '0;
      cur_ch <= arb_idx;
      rr_ptr <= arb_idx;
    end else if (state == MAC) begin
      acc <= acc + OW'(mac_prod);
      tap <= tap + TW'(1);
    end
  end

  // Per-channel delay lines; only the granted channel's history shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          line[c][k] <= '0;
        end
      end
    end else if (grant_en) begin
      for (int k = 1; k < TAPS; k++) begin
        line[arb_idx][k] <= line[arb_idx][k-1];
      end
      line[arb_idx][0] <= new_smp;
    end
  end

  // Coefficient table; writes are ignored while the MAC is reading it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        coef[k] <= DW'(default_coef(k));
      end
    end else if (coef_we && (state != MAC) && (int'(coef_addr) < TAPS)) begin
      coef[coef_addr] <= coef_data;
    end
  end

  assign out_data = acc;
  assign out_ch   = cur_ch;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Self-checking bench: transaction-level FIR model checked against the DUT every cycle.
// Latency: model predicts out_valid TAPS+1 edges after each accept, counting the accepting edge.
// Backpressure: directed out_ready stalls plus random out_ready in the soak phase.
module tb_fir_channel_scheduler;

  localparam int NUM_CH = 4;
  localparam int TAPS   = 4;
  localparam int DW     = 8;
  localparam int OW     = 16;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH*DW-1:0] in_data;
  logic [NUM_CH-1:0] in_ready;
  logic              out_valid;
  logic [OW-1:0]     out_data;
  logic [1:0]        out_ch;
  logic              out_ready;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic [DW-1:0]     coef_data;
  logic              coef_busy;

  fir_channel_scheduler #(
    .NUM_CH (NUM_CH),
    .TAPS   (TAPS),
    .DW     (DW),
    .OW     (OW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_busy (coef_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_hist [NUM_CH][TAPS];
  int          m_coef [TAPS];
  int          m_ptr;
  int          m_phase;      // 0 idle, 1..TAPS computing, TAPS+1 presenting result
  logic [15:0] m_res;
  int          m_ch;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          last_lat = 0;
  logic        ov_prev = 1'b0;
  logic [15:0] log_d [$];
  int          log_c [$];

  always @(negedge clk) begin
    logic              exp_busy;
    logic              exp_ov;
    logic [NUM_CH-1:0] exp_rdy;
    int                win;
    int                sum;
    logic signed [7:0] s8;
    cyc++;
    if (!rst_n) begin
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_ch",    32'(out_ch),    32'd0);
      chk("rst_coef_busy", 32'(coef_busy), 32'd0);
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < TAPS; k++) m_hist[c][k] = 0;
      for (int k = 0; k < TAPS; k++) m_coef[k] = k + 1;
      m_ptr   = NUM_CH - 1;
      m_phase = 0;
    end else begin
      exp_busy = (m_phase >= 1) && (m_phase <= TAPS);
      exp_ov   = (m_phase == TAPS + 1);
      chk("coef_busy", 32'(coef_busy), 32'(exp_busy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) begin
        chk("out_data", 32'(out_data), 32'(m_res));
        chk("out_ch",   32'(out_ch),   32'(m_ch));
      end
      win = -1;
      if (m_phase == 0) begin
        for (int i = 1; i <= NUM_CH; i++) begin
          if (win < 0 && in_valid[(m_ptr + i) % NUM_CH]) win = (m_ptr + i) % NUM_CH;
        end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (out_valid && !ov_prev) last_lat = cyc - acc_cyc;

      // effects of the coming rising edge
      if (coef_we && !exp_busy) begin
        s8 = coef_data;
        m_coef[coef_addr] = int'(s8);
      end
      if (win >= 0) begin
        for (int k = TAPS - 1; k > 0; k--) m_hist[win][k] = m_hist[win][k-1];
        s8 = in_data[win*DW +: DW];
        m_hist[win][0] = int'(s8);
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += m_coef[k] * m_hist[win][k];
        m_res   = 16'(sum);
        m_ch    = win;
        m_ptr   = win;
        m_phase = 1;
        acc_cyc = cyc;
      end else if (exp_busy) begin
        m_phase++;
      end else if (exp_ov && out_ready) begin
        log_d.push_back(out_data);
        log_c.push_back(int'(out_ch));
        m_phase = 0;
      end
    end
    ov_prev = out_valid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = '0; coef_we = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    log_d.delete(); log_c.delete();
  endtask

  task automatic wr_coef(input int a, input int d);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = 2'(a); coef_data = 8'(d);
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  // Hold valid on every channel in mask until each has been accepted.
  task automatic send_multi(input logic [NUM_CH-1:0] mask, input logic [31:0] data);
    logic [NUM_CH-1:0] pend;
    pend = mask;
    @(posedge clk); #1;
    in_data = data; in_valid = pend;
    for (int i = 0; i < 400 && pend != '0; i++) begin
      @(negedge clk);
      if ((in_ready & pend) != '0) begin
        pend = pend & ~in_ready;
        @(posedge clk); #1;
        in_valid = pend;
      end
    end
    if (pend != '0) chk("send_timeout", 32'(pend), 32'd0);
    in_valid = '0;
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 300 && log_d.size() < n; i++) @(negedge clk);
    if (log_d.size() < n) chk("result_timeout", 32'(log_d.size()), 32'(n));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // impulse through channel 0
    send_multi(4'b0001, 32'd1); wait_log(1);
    send_multi(4'b0001, 32'd0); wait_log(2);
    send_multi(4'b0001, 32'd0); wait_log(3);
    send_multi(4'b0001, 32'd0); wait_log(4);
    for (int i = 0; i < 4; i++) begin
      chk("impulse_data", 32'(log_d[i]), 32'(i + 1));
      chk("impulse_ch",   32'(log_c[i]), 32'd0);
    end
    chk("impulse_latency", 32'(last_lat), 32'(TAPS + 1));

    // contention ch0=10, ch2=-5
    do_reset();
    send_multi(4'b0101, 32'h00FB_000A);
    wait_log(2);
    chk("cont_first_ch",   32'(log_c[0]), 32'd0);
    chk("cont_first_data", 32'(log_d[0]), 32'd10);
    chk("cont_second_ch",  32'(log_c[1]), 32'd2);
    chk("cont_second_data",32'(log_d[1]), 32'h0000_FFFB);

    // backpressure: hold result 10 cycles while ch1 waits
    do_reset();
    out_ready = 1'b0;
    send_multi(4'b0001, 32'd3);
    in_data = 32'h0000_0400; in_valid = 4'b0010;
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("bp_held_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1 out_ready = 1'b1;
    for (int i = 0; i < 50 && !in_ready[1]; i++) @(negedge clk);
    @(posedge clk); #1 in_valid = '0;
    wait_log(2);
    chk("bp_first_data",  32'(log_d[0]), 32'd3);
    chk("bp_second_data", 32'(log_d[1]), 32'd4);
    chk("bp_second_ch",   32'(log_c[1]), 32'd1);

    // coefficient write in IDLE, dropped write during MAC
    do_reset();
    wr_coef(0, -1);
    send_multi(4'b0010, 32'h0000_0700);
    wait_log(1);
    chk("coef_neg7", 32'(log_d[0]), 32'h0000_FFF9);
    send_multi(4'b0100, 32'h0001_0000);
    coef_we = 1'b1; coef_addr = 2'd1; coef_data = 8'd9;
    @(negedge clk);
    chk("coef_busy_mac", 32'(coef_busy), 32'd1);
    @(posedge clk); #1 coef_we = 1'b0;
    wait_log(2);
    chk("coef_h0_use", 32'(log_d[1]), 32'h0000_FFFF);
    send_multi(4'b0100, 32'h0000_0000);
    wait_log(3);
    chk("coef_h1_kept", 32'(log_d[2]), 32'd2);

    // accumulator wrap
    do_reset();
    for (int k = 0; k < TAPS; k++) wr_coef(k, -128);
    for (int i = 0; i < 4; i++) begin
      send_multi(4'b1000, 32'h8000_0000);
      wait_log(i + 1);
    end
    chk("wrap_first",  32'(log_d[0]), 32'h0000_4000);
    chk("wrap_fourth", 32'(log_d[3]), 32'd0);
    chk("wrap_ch",     32'(log_c[3]), 32'd3);

    // reset during MAC aborts the operation
    do_reset();
    send_multi(4'b0001, 32'd9);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_busy", 32'(coef_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_multi(4'b0001, 32'd5);
    wait_log(1);
    repeat (3) @(negedge clk);
    chk("abort_count", 32'(log_d.size()), 32'd1);
    chk("abort_next",  32'(log_d[0]), 32'd5);

    // random soak
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom % 4) != 0;
      coef_we   = ($urandom % 8) == 0;
      coef_addr = 2'($urandom);
      coef_data = 8'($urandom);
    end
    @(posedge clk); #1;
    in_valid = '0; coef_we = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("rand_results", 32'(log_d.size() > 50), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
